// File: rtl/seq_mac_feeder_if.sv
// Stream-side and MAC-side bundle for the MAC operand feeder.
// slave: feeder view; master: upstream DMA plus MAC view.
interface seq_mac_feeder_if #(
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int K         = 2,
  parameter int MAX_WIDTH = 16,
  parameter int BSW       = 4
);
  logic [31:0]                 s_data;
  logic                        s_valid;
  logic                        s_last;
  logic                        s_ready;
  logic signed [MAX_WIDTH-1:0] a [M][K];
  logic signed [MAX_WIDTH-1:0] b [K][N];
  logic signed [31:0]          c [M][N];
  logic [BSW-1:0]              bit_size;
  logic                        mac_valid;
  logic                        mac_ready;
  logic                        mac_done;

  modport slave (
    input  s_data, s_valid, s_last, mac_ready, mac_done,
    output s_ready, a, b, c, bit_size, mac_valid
  );

  modport master (
    output s_data, s_valid, s_last, mac_ready, mac_done,
    input  s_ready, a, b, c, bit_size, mac_valid
  );
endinterface

// File: rtl/seq_mac_feeder.sv
// Collects one A/B/C tile from a 32-bit element stream, then presents it
// to the bit-serial MAC and holds the operands until the MAC is done.
//
// state  | meaning
// LOAD_A | accepting M*K A elements, first beat samples bit size
// LOAD_B | accepting K*N B elements
// LOAD_C | accepting M*N C elements, final beat must carry s_last
// ISSUE  | mac_valid high, waiting for mac_ready
// WAIT   | operands frozen while the MAC runs, waiting for mac_done
module seq_mac_feeder #(
  parameter int  M         = 2,
  parameter int  N         = 2,
  parameter int  K         = 2,
  parameter int  MAX_WIDTH = 16,
  parameter int  P         = 2,
  localparam int BSW       = $clog2(MAX_WIDTH / P) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  seq_mac_feeder_if.slave     bus,
  input  logic [BSW-1:0]      bit_size_i,
  output logic                err_o,
  output logic [15:0]         tiles_o
);

  localparam int MK   = M * K;
  localparam int KN   = K * N;
  localparam int MN   = M * N;
  localparam int MAXB = (MK > KN) ? ((MK > MN) ? MK : MN) : ((KN > MN) ? KN : MN);
  localparam int CW   = $clog2(MAXB + 1);
  localparam logic [BSW-1:0] FULL_BS = BSW'(MAX_WIDTH / P);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_C, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_d;
  logic          in_load, accept, bs_bad, first_a;

  assign in_load       = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_C);
  // Gate with reset so the stream never sees ready while the block is held in reset.
  assign bus.s_ready   = in_load & rst_ni;
  assign accept        = bus.s_valid & bus.s_ready;
  assign bus.mac_valid = (state_q == ISSUE);
  assign bs_bad        = (bit_size_i == '0) || (bit_size_i > FULL_BS);
  assign first_a       = accept && (state_q == LOAD_A) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      LOAD_A: if (accept) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0 && bs_bad) err_d = 1'b1;
        if (bus.s_last) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else if (cnt_q == CW'(MK - 1)) begin
          state_d = LOAD_B;
          cnt_d   = '0;
        end
      end
      LOAD_B: if (accept) begin
        cnt_d = cnt_q + 1'b1;
        if (bus.s_last) begin
          err_d   = 1'b1;
          state_d = LOAD_A;
          cnt_d   = '0;
        end else if (cnt_q == CW'(KN - 1)) begin
          state_d = LOAD_C;
          cnt_d   = '0;
        end
      end
      LOAD_C: if (accept) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MN - 1)) begin
          // A missing s_last on the final beat is flagged but the tile still goes out.
          err_d   = ~bus.s_last;
          state_d = ISSUE;
          cnt_d   = '0;
        end else if (bus.s_last) begin
          err_d   = 1'b1;
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      end
      ISSUE: if (bus.mac_ready) state_d = WAIT;
      WAIT:  if (bus.mac_done)  state_d = LOAD_A;
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      err_o   <= 1'b0;
      tiles_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_o   <= err_d;
      if (state_q == ISSUE && bus.mac_ready) tiles_o <= tiles_o + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.bit_size <= FULL_BS;
    end else if (first_a) begin
      bus.bit_size <= bs_bad ? FULL_BS : bit_size_i;
    end
  end

  // Operand registers only move on accepted beats, so ISSUE/WAIT keep them frozen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < M; r++)
        for (int k = 0; k < K; k++) bus.a[r][k] <= '0;
      for (int k = 0; k < K; k++)
        for (int n = 0; n < N; n++) bus.b[k][n] <= '0;
      for (int r = 0; r < M; r++)
        for (int n = 0; n < N; n++) bus.c[r][n] <= '0;
    end else if (accept) begin
      case (state_q)
        LOAD_A:
          for (int r = 0; r < M; r++)
            for (int k = 0; k < K; k++)
              if (cnt_q == CW'(r * K + k)) bus.a[r][k] <= bus.s_data[MAX_WIDTH-1:0];
        LOAD_B:
          for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
              if (cnt_q == CW'(k * N + n)) bus.b[k][n] <= bus.s_data[MAX_WIDTH-1:0];
        LOAD_C:
          for (int r = 0; r < M; r++)
            for (int n = 0; n < N; n++)
              if (cnt_q == CW'(r * N + n)) bus.c[r][n] <= bus.s_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mac_feeder.sv
// Self-checking bench for seq_mac_feeder: table of directed tiles, a reset
// sequence, then random tiles checked against a tile-level reference model.
module tb_seq_mac_feeder;
  localparam int M    = 2;
  localparam int N    = 2;
  localparam int K    = 2;
  localparam int MW   = 16;
  localparam int P    = 2;
  localparam int BSW  = $clog2(MW / P) + 1;
  localparam int FULL = MW / P;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [BSW-1:0] bit_size_i = '0;
  logic           err_o;
  logic [15:0]    tiles_o;

  seq_mac_feeder_if #(.M(M), .N(N), .K(K), .MAX_WIDTH(MW), .BSW(BSW)) bus ();

  seq_mac_feeder #(.M(M), .N(N), .K(K), .MAX_WIDTH(MW), .P(P)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .bus        (bus),
    .bit_size_i (bit_size_i),
    .err_o      (err_o),
    .tiles_o    (tiles_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] e [12];
    int          last_pos;
    int          bs;
    int          dly;
    bit          probe;
    int          exp_bs;
    int          exp_err;
    bit          exp_issue;
  } vec_t;

  vec_t tbl [6];
  int   errors = 0;
  int   checks = 0;
  int   err_cnt = 0;
  int   tiles_exp = 0;

  always @(negedge clk_i) if (err_o === 1'b1) err_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t base_vec();
    vec_t v;
    v.e         = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0};
    v.last_pos  = 11;
    v.bs        = 8;
    v.dly       = 0;
    v.probe     = 1'b0;
    v.exp_bs    = 8;
    v.exp_err   = 0;
    v.exp_issue = 1'b1;
    return v;
  endfunction

  // Tile-level rules: bad size clamps and flags; any s_last other than
  // exactly on beat 11 flags; only tiles that reach beat 11 are issued.
  function automatic vec_t model(input vec_t v);
    vec_t o;
    bit   bad;
    o         = v;
    bad       = (v.bs == 0) || (v.bs > FULL);
    o.exp_bs  = bad ? FULL : v.bs;
    o.exp_issue = (v.last_pos >= 11);
    o.exp_err = int'(bad) + int'(v.last_pos != 11) - int'(bad && v.last_pos == 0);
    return o;
  endfunction

  task automatic check_ops(input vec_t v);
    for (int r = 0; r < M; r++)
      for (int k = 0; k < K; k++)
        chk($sformatf("a_o[%0d][%0d]", r, k), int'(bus.a[r][k]), int'($signed(v.e[r*K+k][15:0])));
    for (int k = 0; k < K; k++)
      for (int n = 0; n < N; n++)
        chk($sformatf("b_o[%0d][%0d]", k, n), int'(bus.b[k][n]), int'($signed(v.e[4+k*N+n][15:0])));
    for (int r = 0; r < M; r++)
      for (int n = 0; n < N; n++)
        chk($sformatf("c_o[%0d][%0d]", r, n), int'(bus.c[r][n]), int'($signed(v.e[8+r*N+n])));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input bit l, output bit ok);
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      ok = (bus.s_ready === 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  task automatic run_tile(input vec_t v);
    bit ok;
    int base;
    int n;
    int vcnt;
    base = err_cnt;
    bit_size_i = BSW'(v.bs);
    n = v.exp_issue ? 12 : v.last_pos + 1;
    for (int i = 0; i < n; i++) begin
      send_beat(v.e[i], (i == v.last_pos), ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL beat_accept: beat %0d not accepted within budget", i);
        break;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!v.exp_issue) begin
      chk("abort_mac_valid", int'(bus.mac_valid), 0);
      chk("abort_s_ready", int'(bus.s_ready), 1);
      @(posedge clk_i);
      @(negedge clk_i);
      chk("abort_err_pulses", err_cnt - base, v.exp_err);
      chk("abort_tiles", int'(tiles_o), tiles_exp);
      return;
    end
    chk("latency_mac_valid", int'(bus.mac_valid), 1);
    chk("issue_s_ready", int'(bus.s_ready), 0);
    chk("bit_size_o", int'(bus.bit_size), v.exp_bs);
    check_ops(v);
    vcnt = 1;
    if (v.dly > 0) bus.mac_done = 1'b1;
    for (int j = 0; j < v.dly; j++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (bus.mac_valid === 1'b1) vcnt++;
      chk("hold_s_ready", int'(bus.s_ready), 0);
      check_ops(v);
    end
    bus.mac_done  = 1'b0;
    bus.mac_ready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.mac_ready = 1'b0;
    tiles_exp = (tiles_exp + 1) & 16'hFFFF;
    chk("valid_drop", int'(bus.mac_valid), 0);
    chk("valid_cycles", vcnt, v.dly + 1);
    chk("tiles_o", int'(tiles_o), tiles_exp);
    if (v.probe) begin
      bus.s_valid = 1'b1;
      bus.s_data  = $urandom;
      bit_size_i  = BSW'(v.bs + 1);
      for (int j = 0; j < 3; j++) begin
        @(posedge clk_i);
        @(negedge clk_i);
        chk("wait_s_ready", int'(bus.s_ready), 0);
        chk("wait_bit_size", int'(bus.bit_size), v.exp_bs);
        check_ops(v);
      end
    end
    bus.mac_done = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.mac_done = 1'b0;
    bus.s_valid  = 1'b0;
    chk("done_s_ready", int'(bus.s_ready), 1);
    chk("tile_err_pulses", err_cnt - base, v.exp_err);
  endtask

  initial begin
    vec_t v;
    bit   ok;
    int   sel;

    bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.mac_ready = 1'b0; bus.mac_done = 1'b0;

    // Directed table: {stream, last position, size, ready delay, wait probe} -> expectations.
    tbl[0] = base_vec();
    tbl[1] = base_vec(); tbl[1].dly = 5; tbl[1].probe = 1'b1;
    tbl[2] = base_vec(); tbl[2].last_pos = 4; tbl[2].exp_err = 1; tbl[2].exp_issue = 1'b0;
    tbl[3] = base_vec(); tbl[3].bs = 0; tbl[3].exp_bs = 8; tbl[3].exp_err = 1;
    tbl[4] = base_vec(); tbl[4].bs = 9; tbl[4].exp_bs = 8; tbl[4].exp_err = 1; tbl[4].dly = 2;
    tbl[5] = base_vec(); tbl[5].bs = 3; tbl[5].exp_bs = 3; tbl[5].last_pos = 12; tbl[5].exp_err = 1;
    tbl[5].e[0] = 32'h0001_FFFE; tbl[5].e[8] = 32'hDEAD_BEEF; tbl[5].e[11] = 32'hFFFF_FFFB;

    #12;
    chk("rst_s_ready", int'(bus.s_ready), 0);
    chk("rst_mac_valid", int'(bus.mac_valid), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_tiles", int'(tiles_o), 0);
    chk("rst_bit_size", int'(bus.bit_size), FULL);
    chk("rst_a00", int'(bus.a[0][0]), 0);
    chk("rst_c11", int'(bus.c[1][1]), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_s_ready", int'(bus.s_ready), 1);
    @(negedge clk_i);

    for (int t = 0; t < 6; t++) run_tile(tbl[t]);

    // Reset while loading C: everything returns to reset values, nothing issues.
    v = base_vec();
    bit_size_i = 4'd5;
    for (int i = 0; i < 9; i++) send_beat(v.e[i], 1'b0, ok);
    bus.s_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("midrst_s_ready", int'(bus.s_ready), 0);
    chk("midrst_mac_valid", int'(bus.mac_valid), 0);
    chk("midrst_tiles", int'(tiles_o), 0);
    chk("midrst_bit_size", int'(bus.bit_size), FULL);
    chk("midrst_a00", int'(bus.a[0][0]), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tiles_exp = 0;
    @(negedge clk_i);
    chk("midrst_rel_mac_valid", int'(bus.mac_valid), 0);
    chk("midrst_rel_tiles", int'(tiles_o), 0);
    v.e[0] = 32'hFFFF_8000;
    run_tile(v);
    chk("a00_negative", int'(bus.a[0][0]), -32768);

    // Random tiles against the tile-level model.
    for (int t = 0; t < 30; t++) begin
      v = base_vec();
      for (int i = 0; i < 12; i++) v.e[i] = $urandom;
      v.bs = $urandom_range(0, 10);
      sel = $urandom_range(0, 9);
      if (sel < 7)       v.last_pos = 11;
      else if (sel == 7) v.last_pos = 12;
      else               v.last_pos = $urandom_range(1, 10);
      v.dly   = $urandom_range(0, 3);
      v.probe = ($urandom_range(0, 1) == 1);
      run_tile(model(v));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
